hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control_pkg.sv | 83 ++++++++
 rtl/hazard_control_if.sv | 50 +++++
 rtl/hazard_control_detect.sv | 40 ++++
 rtl/hazard_control.sv | 109 ++++++++++
 tb/tb_hazard_control.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the pipeline hazard controller:
//   - FSM state encoding (RUN / MUL_BUSY)
//   - default multiply occupancy and stall-counter width
//   - the bundle of pipeline control outputs, plus constructors for each of
//     the control patterns the controller can emit.
// ---------------------------------------------------------------------------
package pipeline_pkg;

  // FSM state encoding.
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  // Multiply occupancy of EX, in cycles (legal range 2..15).
  localparam int MUL_CYCLES_DEFAULT = 4;

  // Width of the multiply down-counter (holds at most 15 - 2 = 13).
  localparam int MUL_CNT_W = 4;

  // Default width of the stall performance counter.
  localparam int STALL_CNT_W_DEFAULT = 16;

  // Pipeline control outputs, most significant field first.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic idex_hold;
    logic exmem_bubble;
    logic busy;
  } hz_ctrl_t;

  // Normal flow: everything advances, nothing is flushed.
  function automatic hz_ctrl_t ctrl_run_default();
    hz_ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    return c;
  endfunction

  // While reset is held the pipeline is frozen and filled with bubbles.
  function automatic hz_ctrl_t ctrl_reset();
    hz_ctrl_t c;
    c              = '0;
    c.ifid_flush   = 1'b1;
    c.idex_flush   = 1'b1;
    c.exmem_bubble = 1'b1;
    return c;
  endfunction

  // Taken branch: keep fetching from the new target, squash the two younger
  // instructions already in IF/ID and ID/EX.
  function automatic hz_ctrl_t ctrl_branch();
    hz_ctrl_t c;
    c            = ctrl_run_default();
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Load-use: freeze PC and IF/ID, inject one bubble into ID/EX.
  function automatic hz_ctrl_t ctrl_load_use();
    hz_ctrl_t c;
    c            = '0;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Multiply occupying EX: freeze the front end, keep the multiply in ID/EX,
  // and feed bubbles downstream until the result is ready.
  function automatic hz_ctrl_t ctrl_mul_stall(input logic busy);
    hz_ctrl_t c;
    c              = '0;
    c.idex_hold    = 1'b1;
    c.exmem_bubble = 1'b1;
    c.busy         = busy;
    return c;
  endfunction

endpackage : pipeline_pkg

// File: rtl/hazard_control_if.sv
// ---------------------------------------------------------------------------
// hazard_control_if
//   Bundle between the pipeline datapath and the hazard controller.
//   Datapath -> controller : rs_ID, rt_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
//                            BranchTaken_EX, MulStart_EX
//   Controller -> datapath : PCWrite, IFIDWrite, IFIDFlush, IDEXFlush,
//                            IDEXHold, EXMEMBubble, Busy, StallCount[CNT_W]
//   modport master : datapath side (drives hazard inputs, receives controls)
//   modport slave  : controller side
// ---------------------------------------------------------------------------
interface hazard_control_if
  import pipeline_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W_DEFAULT
);

  // Hazard inputs from the pipeline.
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             UsesRt_ID;
  logic             MemRead_EX;
  logic [4:0]       WriteReg_EX;
  logic             BranchTaken_EX;
  logic             MulStart_EX;

  // Control outputs to the pipeline.
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             IDEXHold;
  logic             EXMEMBubble;
  logic             Busy;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output rs_ID, rt_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
           BranchTaken_EX, MulStart_EX,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, IDEXHold,
           EXMEMBubble, Busy, StallCount
  );

  modport slave (
    input  rs_ID, rt_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
           BranchTaken_EX, MulStart_EX,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, IDEXHold,
           EXMEMBubble, Busy, StallCount
  );

endinterface : hazard_control_if

// File: rtl/hazard_control_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use detector.
//   Inputs : rs_ID, rt_ID   source fields of the IF/ID instruction
//            UsesRt_ID      IF/ID instruction actually reads rt
//            MemRead_EX     ID/EX instruction is a load
//            WriteReg_EX    destination of the ID/EX instruction
//   Output : LoadUse        IF/ID needs the load result one cycle too early
// ---------------------------------------------------------------------------
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       UsesRt_ID,
  input  logic       MemRead_EX,
  input  logic [4:0] WriteReg_EX,
  output logic       LoadUse
);

  // Source operand slots: 0 = rs (always read), 1 = rt (read only when used).
  logic [4:0] w_src [2];
  logic [1:0] w_src_en;
  logic [1:0] w_match;

  assign w_src[0] = rs_ID;
  assign w_src[1] = rt_ID;
  assign w_src_en = {UsesRt_ID, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_match[gi] = w_src_en[gi] && (WriteReg_EX == w_src[gi]);
    end
  endgenerate

  // $0 is hardwired to zero, so a load targeting it creates no dependency.
  assign LoadUse = MemRead_EX && (WriteReg_EX != 5'd0) && (|w_match);

endmodule : hazard_detect

// File: rtl/hazard_control.sv
// ---------------------------------------------------------------------------
// hazard_control
//   Pipeline hazard controller for a 5-stage pipeline with a multi-cycle
//   multiplier in EX. Resolves, in priority order, taken branches, multiply
//   occupancy of EX, and load-use dependencies, and counts stall cycles.
//   Ports:
//     Clk    single clock, all state on the rising edge
//     Reset  synchronous, active-high
//     bus    hazard_control_if.slave (hazard inputs in, pipeline controls out)
//   Parameters:
//     MUL_CYCLES  EX occupancy of a multiply, 2..15
//     CNT_W       width of StallCount; must match bus CNT_W
// ---------------------------------------------------------------------------
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int CNT_W      = STALL_CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  hazard_control_if.slave  bus
);

  // The first EX cycle of a multiply is spent in RUN and the last one
  // (counter at zero) releases the pipeline, hence the "- 2".
  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  logic [0:0]           r_state;
  logic [MUL_CNT_W-1:0] r_mul_cnt;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic [0:0]           w_state_next;
  logic [MUL_CNT_W-1:0] w_mul_cnt_next;
  logic                 w_load_use;
  hz_ctrl_t             w_ctl;

  hazard_detect u_detect (
    .rs_ID       (bus.rs_ID),
    .rt_ID       (bus.rt_ID),
    .UsesRt_ID   (bus.UsesRt_ID),
    .MemRead_EX  (bus.MemRead_EX),
    .WriteReg_EX (bus.WriteReg_EX),
    .LoadUse     (w_load_use)
  );

  // Control outputs and next state.
  always_comb begin
    w_ctl          = ctrl_run_default();
    w_state_next   = r_state;
    w_mul_cnt_next = r_mul_cnt;

    if (Reset) begin
      w_ctl          = ctrl_reset();
      w_state_next   = ST_RUN;
      w_mul_cnt_next = '0;
    end else if (r_state == ST_MUL_BUSY) begin
      // The multiply owns EX: branch, load-use and a new MulStart_EX
      // presented meanwhile are not acted upon.
      if (r_mul_cnt != '0) begin
        w_ctl          = ctrl_mul_stall(1'b1);
        w_mul_cnt_next = r_mul_cnt - 1'b1;
      end else begin
        // Result is captured this cycle; the pipeline advances normally.
        w_state_next = ST_RUN;
      end
    end else begin
      if (bus.BranchTaken_EX) begin
        // Anything behind a taken branch is squashed, including a multiply
        // or a load-use consumer that would otherwise have stalled.
        w_ctl = ctrl_branch();
      end else if (bus.MulStart_EX) begin
        w_ctl          = ctrl_mul_stall(1'b0);
        w_state_next   = ST_MUL_BUSY;
        w_mul_cnt_next = MUL_LOAD;
      end else if (w_load_use) begin
        // Bubble goes into ID/EX, so the load leaves EX next cycle and the
        // stall lasts exactly one cycle.
        w_ctl = ctrl_load_use();
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_RUN;
      r_mul_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mul_cnt <= w_mul_cnt_next;
      // Saturating count of cycles in which fetch was frozen.
      if (!w_ctl.pc_write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign bus.PCWrite     = w_ctl.pc_write;
  assign bus.IFIDWrite   = w_ctl.ifid_write;
  assign bus.IFIDFlush   = w_ctl.ifid_flush;
  assign bus.IDEXFlush   = w_ctl.idex_flush;
  assign bus.IDEXHold    = w_ctl.idex_hold;
  assign bus.EXMEMBubble = w_ctl.exmem_bubble;
  assign bus.Busy        = w_ctl.busy;
  assign bus.StallCount  = r_stall_cnt;

endmodule : hazard_control

// File: tb/tb_hazard_control.sv
// ---------------------------------------------------------------------------
// tb_hazard_control
//   Self-checking bench for hazard_control. Each task builds a short table of
//   per-cycle stimulus with its expected controls and stall count, pushes the
//   expectation when the stimulus is applied and pops/compares it when the
//   combinational outputs have settled (falling edge).
//   Control vector order: {PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,IDEXHold,
//                          EXMEMBubble,Busy}
// ---------------------------------------------------------------------------
module tb_hazard_control;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_control_if #(.CNT_W(16)) hz ();
  hazard_control_if #(.CNT_W(4))  hz4 ();

  hazard_control #(.MUL_CYCLES(4), .CNT_W(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (hz)
  );

  hazard_control #(.MUL_CYCLES(4), .CNT_W(4)) dut4 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (hz4)
  );

  localparam logic [6:0] CTL_DEF  = 7'b1100000;
  localparam logic [6:0] CTL_RST  = 7'b0011010;
  localparam logic [6:0] CTL_LU   = 7'b0001000;
  localparam logic [6:0] CTL_MUL0 = 7'b0000110;
  localparam logic [6:0] CTL_MULB = 7'b0000111;
  localparam logic [6:0] CTL_BR   = 7'b1111000;

  typedef struct {
    string      name;
    logic       rst;
    logic       br;
    logic       ms;
    logic       mr;
    logic [4:0] wr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic [6:0] ctl;
    logic [15:0] cnt;
  } step_t;

  step_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic step_t mk(input string name, input logic r, input logic br,
                               input logic ms, input logic mr, input logic [4:0] wr,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic [6:0] ctl,
                               input logic [15:0] cnt);
    step_t s;
    s.name = name; s.rst = r; s.br = br; s.ms = ms; s.mr = mr;
    s.wr = wr; s.rs = rs; s.rt = rt; s.urt = urt; s.ctl = ctl; s.cnt = cnt;
    return s;
  endfunction

  function automatic logic [6:0] obs_ctl();
    return {hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXFlush,
            hz.IDEXHold, hz.EXMEMBubble, hz.Busy};
  endfunction

  function automatic logic [6:0] obs_ctl4();
    return {hz4.PCWrite, hz4.IFIDWrite, hz4.IFIDFlush, hz4.IDEXFlush,
            hz4.IDEXHold, hz4.EXMEMBubble, hz4.Busy};
  endfunction

  task automatic apply(input step_t s);
    rst               = s.rst;
    hz.BranchTaken_EX = s.br;
    hz.MulStart_EX    = s.ms;
    hz.MemRead_EX     = s.mr;
    hz.WriteReg_EX    = s.wr;
    hz.rs_ID          = s.rs;
    hz.rt_ID          = s.rt;
    hz.UsesRt_ID      = s.urt;
  endtask

  task automatic apply4(input step_t s);
    rst                = s.rst;
    hz4.BranchTaken_EX = s.br;
    hz4.MulStart_EX    = s.ms;
    hz4.MemRead_EX     = s.mr;
    hz4.WriteReg_EX    = s.wr;
    hz4.rs_ID          = s.rs;
    hz4.rt_ID          = s.rt;
    hz4.UsesRt_ID      = s.urt;
  endtask

  task automatic test_reset();
    step_t st[$];
    step_t e;
    st.push_back(mk("reset_held",  1, 0, 0, 0, 0, 0, 0, 0, CTL_RST, 16'd0));
    st.push_back(mk("first_after", 0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF, 16'd0));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("reset   %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    step_t e;
    st.push_back(mk("lu_rs",       0, 0, 0, 1, 8, 8, 0, 0, CTL_LU,  16'd0));
    st.push_back(mk("lu_rs_after", 0, 0, 0, 0, 0, 8, 0, 0, CTL_DEF, 16'd1));
    st.push_back(mk("lu_rt",       0, 0, 0, 1, 9, 3, 9, 1, CTL_LU,  16'd1));
    st.push_back(mk("lu_rt_after", 0, 0, 0, 0, 0, 3, 9, 1, CTL_DEF, 16'd2));
    st.push_back(mk("rt_unused",   0, 0, 0, 1, 9, 3, 9, 0, CTL_DEF, 16'd2));
    st.push_back(mk("no_match",    0, 0, 0, 1, 8, 7, 8, 0, CTL_DEF, 16'd2));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("loaduse %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wr0();
    step_t st[$];
    step_t e;
    st.push_back(mk("wr0_load",  0, 0, 0, 1, 0, 0, 0, 1, CTL_DEF, 16'd2));
    st.push_back(mk("wr0_after", 0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF, 16'd2));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("wr0     %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    step_t st[$];
    step_t e;
    // Branch / load-use / MulStart presented while busy must be ignored.
    st.push_back(mk("mul_start", 0, 0, 1, 0, 0, 0, 0, 0, CTL_MUL0, 16'd2));
    st.push_back(mk("mul_busy1", 0, 1, 1, 1, 8, 8, 0, 0, CTL_MULB, 16'd3));
    st.push_back(mk("mul_busy2", 0, 1, 0, 0, 0, 0, 0, 0, CTL_MULB, 16'd4));
    st.push_back(mk("mul_done",  0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd5));
    st.push_back(mk("mul_after", 0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd5));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("mul     %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    step_t st[$];
    step_t e;
    st.push_back(mk("br_all",   0, 1, 1, 1, 8, 8, 0, 0, CTL_BR,  16'd5));
    st.push_back(mk("br_after", 0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF, 16'd5));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("branch  %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    step_t e;
    st.push_back(mk("m1_start", 0, 0, 1, 0, 0, 0, 0, 0, CTL_MUL0, 16'd5));
    st.push_back(mk("m1_busy1", 0, 0, 0, 0, 0, 0, 0, 0, CTL_MULB, 16'd6));
    st.push_back(mk("m1_busy2", 0, 0, 0, 0, 0, 0, 0, 0, CTL_MULB, 16'd7));
    st.push_back(mk("m1_done",  0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd8));
    st.push_back(mk("m2_start", 0, 0, 1, 0, 0, 0, 0, 0, CTL_MUL0, 16'd8));
    st.push_back(mk("m2_busy1", 0, 0, 0, 0, 0, 0, 0, 0, CTL_MULB, 16'd9));
    st.push_back(mk("m2_busy2", 0, 0, 0, 0, 0, 0, 0, 0, CTL_MULB, 16'd10));
    st.push_back(mk("m2_done",  0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd11));
    st.push_back(mk("lu_a",     0, 0, 0, 1, 3, 3, 0, 0, CTL_LU,   16'd11));
    st.push_back(mk("lu_b",     0, 0, 0, 1, 4, 1, 4, 1, CTL_LU,   16'd12));
    st.push_back(mk("lu_done",  0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd13));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("b2b     %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mul();
    step_t st[$];
    step_t e;
    st.push_back(mk("rm_start", 0, 0, 1, 0, 0, 0, 0, 0, CTL_MUL0, 16'd13));
    st.push_back(mk("rm_busy1", 0, 0, 0, 0, 0, 0, 0, 0, CTL_MULB, 16'd14));
    st.push_back(mk("rm_reset", 1, 0, 1, 1, 8, 8, 0, 0, CTL_RST,  16'd15));
    st.push_back(mk("rm_rel",   0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd0));
    st.push_back(mk("rm_rel2",  0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF,  16'd0));
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (hz.StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz.StallCount, e.cnt);
      end
      $display("rstmul  %-12s ctl=%b cnt=%0d", e.name, obs_ctl(), hz.StallCount);
      @(posedge clk); #1;
    end
  endtask

  // Narrow counter instance: 20 load-use cycles must pin StallCount at 15.
  task automatic test_saturation();
    step_t st[$];
    step_t e;
    for (int i = 0; i < 20; i++) begin
      st.push_back(mk($sformatf("sat_%0d", i), 0, 0, 0, 1, 5, 5, 0, 0, CTL_LU,
                      (i < 15) ? 16'(i) : 16'd15));
    end
    st.push_back(mk("sat_idle", 0, 0, 0, 0, 0, 0, 0, 0, CTL_DEF, 16'd15));
    foreach (st[k]) begin
      apply4(st[k]);
      sb.push_back(st[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl4() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b expected %b", e.name, obs_ctl4(), e.ctl);
      end
      checks++;
      if ({12'd0, hz4.StallCount} !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount got %0d expected %0d", e.name, hz4.StallCount, e.cnt);
      end
      $display("sat     %-12s ctl=%b cnt=%0d", e.name, obs_ctl4(), hz4.StallCount);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, CTL_RST, 16'd0));
    apply4(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, CTL_RST, 16'd0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_wr0();
    test_mul();
    test_branch_priority();
    test_back_to_back();
    test_reset_mid_mul();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_control
